// File: rtl/sccb_sender_if.sv
// Request handshake and SCCB bus signals between the config sequencer and sccb_sender.
// The sender is the slave; the sequencer (or bench) uses the master view.
interface sccb_sender_if;
    logic       data_vld;
    logic [7:0] addr;
    logic [7:0] value;
    logic       SCCB_done;
    logic       busy;
    logic       sio_c;
    logic       sio_d_out;
    logic       sio_d_oe;

    modport master (
        output data_vld, addr, value,
        input  SCCB_done, busy, sio_c, sio_d_out, sio_d_oe
    );

    modport slave (
        input  data_vld, addr, value,
        output SCCB_done, busy, sio_c, sio_d_out, sio_d_oe
    );
endinterface

// File: rtl/sccb_sender.sv
// SCCB 3-phase write sender: ID/addr/value frame with start and stop conditions,
// one transaction per data_vld, power-up wait with a kick-off SCCB_done pulse.
module sccb_sender #(
    parameter int unsigned QTR       = 63,
    parameter int unsigned INIT_WAIT = 25000,
    parameter logic [7:0]  DEV_ID    = 8'h42
) (
    input logic          clk,
    input logic          rst_n,
    sccb_sender_if.slave bus
);

    localparam int unsigned QW = (QTR > 1) ? $clog2(QTR) : 1;
    localparam int unsigned WW = (INIT_WAIT > 1) ? $clog2(INIT_WAIT + 1) : 1;

    typedef enum logic [2:0] {INIT, IDLE, CAPT, START, BITS, STOP} state_t;

    state_t          state, n_state;
    logic [QW-1:0]   qcnt, n_qcnt;
    logic [1:0]      phase, n_phase;
    logic [4:0]      bit_idx, n_bit;
    logic [26:0]     frame, n_frame;
    logic [WW-1:0]   wait_cnt, n_wait;
    logic            n_done, n_busy;
    logic            n_c, n_d, n_oe;
    logic            q_end, bit_end;
    logic [4:0]      n_pos;

    // Next-state decode; bus levels are derived from the next state so the
    // registered outputs line up with the state they describe.
    always_comb begin
        n_state = state;
        n_qcnt  = qcnt;
        n_phase = phase;
        n_bit   = bit_idx;
        n_frame = frame;
        n_wait  = wait_cnt;
        n_done  = 1'b0;
        n_busy  = bus.busy;
        q_end   = (qcnt == QW'(QTR - 1));
        bit_end = q_end && (phase == 2'd3);

        if (q_end) begin
            n_qcnt  = '0;
            n_phase = phase + 1'b1;
        end else begin
            n_qcnt  = qcnt + 1'b1;
        end

        case (state)
            INIT: begin
                if (wait_cnt == WW'(INIT_WAIT - 1)) begin
                    n_state = IDLE;
                    n_done  = 1'b1;
                    n_wait  = '0;
                end else begin
                    n_wait  = wait_cnt + 1'b1;
                end
            end
            IDLE: begin
                if (bus.data_vld) begin
                    n_state = CAPT;
                    n_busy  = 1'b1;
                end
            end
            CAPT: begin
                n_frame = {DEV_ID, 1'b1, bus.addr, 1'b1, bus.value, 1'b1};
                n_state = START;
            end
            START: begin
                if (bit_end) begin
                    n_state = BITS;
                    n_bit   = '0;
                end
            end
            BITS: begin
                if (bit_end) begin
                    if (bit_idx == 5'd26) n_state = STOP;
                    else                  n_bit   = bit_idx + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    n_state = IDLE;
                    n_done  = 1'b1;
                    n_busy  = 1'b0;
                end
            end
            default: n_state = INIT;
        endcase

        if (n_state != state) begin
            n_qcnt  = '0;
            n_phase = '0;
        end

        n_pos = 5'd26 - n_bit;
        n_c   = 1'b1;
        n_d   = 1'b1;
        n_oe  = 1'b1;
        case (n_state)
            START: begin
                n_c = (n_phase != 2'd3);
                n_d = (n_phase == 2'd0);
            end
            BITS: begin
                n_c  = (n_phase == 2'd1) || (n_phase == 2'd2);
                n_d  = n_frame[n_pos];
                n_oe = !((n_bit == 5'd8) || (n_bit == 5'd17) || (n_bit == 5'd26));
            end
            STOP: begin
                n_c = (n_phase != 2'd0);
                n_d = n_phase[1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= INIT;
            qcnt          <= '0;
            phase         <= '0;
            bit_idx       <= '0;
            frame         <= '0;
            wait_cnt      <= '0;
            bus.SCCB_done <= 1'b0;
            bus.busy      <= 1'b0;
            bus.sio_c     <= 1'b1;
            bus.sio_d_out <= 1'b1;
            bus.sio_d_oe  <= 1'b1;
        end else begin
            state         <= n_state;
            qcnt          <= n_qcnt;
            phase         <= n_phase;
            bit_idx       <= n_bit;
            frame         <= n_frame;
            wait_cnt      <= n_wait;
            bus.SCCB_done <= n_done;
            bus.busy      <= n_busy;
            bus.sio_c     <= n_c;
            bus.sio_d_out <= n_d;
            bus.sio_d_oe  <= n_oe;
        end
    end

endmodule

// File: doc/sccb_sender.md
SCCB_SENDER -- requirements
Module: sccb_sender

Interface
REQ-001 Parameter QTR, default 63: clk cycles per quarter SCCB bit; 4*QTR = 252 cycles per bit (~99 kHz at 25 MHz).
REQ-002 Parameter INIT_WAIT, default 25000: clk cycles of post-reset power-up wait (1 ms at 25 MHz).
REQ-003 Parameter DEV_ID, default 8'h42: SCCB write ID byte.
REQ-004 clk  in  1  system clock, 25 MHz.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 data_vld  in  1  one-cycle request from config sequencer.
REQ-007 addr  in  8  register address; valid from the cycle after data_vld.
REQ-008 value  in  8  register data; valid from the cycle after data_vld.
REQ-009 SCCB_done  out  1  one-cycle pulse: ready for next request / transaction finished.
REQ-010 busy  out  1  high from request capture until SCCB_done pulse.
REQ-011 sio_c  out  1  SCCB clock.
REQ-012 sio_d_out  out  1  SCCB data drive value.
REQ-013 sio_d_oe  out  1  1 = drive sio_d_out, 0 = release (high-Z at top level).

Function
REQ-014 States SHALL be INIT, IDLE, CAPT, START, BITS, STOP; a free-running quarter counter 0..QTR-1 advances the bus sub-phase q0..q3; it is cleared on every state entry.
REQ-015 INIT: count INIT_WAIT cycles, then enter IDLE and pulse SCCB_done once (kick-off for the sequencer).
REQ-016 IDLE: sio_c=1, sio_d_out=1, sio_d_oe=1, busy=0; data_vld=1 -> CAPT next cycle, busy=1.
REQ-017 CAPT (exactly 1 cycle): latch addr and value into a 27-bit shift frame {DEV_ID,x,addr,x,value,x}; enter START.
REQ-018 START, one bit time: q0 C=1 D=1; q1..q2 C=1 D=0 (start condition); q3 C=0 D=0.
REQ-019 BITS, 27 bit times, MSB first: q0 C=0 D=bit set; q1..q2 C=1; q3 C=0; a 5-bit counter 0..26 indexes bits.
REQ-020 Bit indices 8, 17, 26 (don't-care/ACK) SHALL have sio_d_oe=0 for the full bit time; ACK value is not checked.
REQ-021 STOP, one bit time: q0 C=0 D=0; q1 C=1 D=0; q2..q3 C=1 D=1 (stop condition); then IDLE.
REQ-022 SCCB_done SHALL pulse high for exactly the first IDLE cycle after STOP, busy falls in the same cycle.
REQ-023 Transaction length SHALL be 1 (CAPT) + 116*QTR cycles from data_vld+1 to SCCB_done.
REQ-024 data_vld during INIT, CAPT, START, BITS or STOP SHALL be ignored (no queueing, no frame corruption).
REQ-025 data_vld coincident with the SCCB_done cycle SHALL be accepted.
REQ-026 sio_d transitions SHALL occur only while sio_c=0, except start/stop edges.
REQ-027 All outputs SHALL be registered; no glitches on sio_c/sio_d.

Reset
REQ-028 rst_n low SHALL immediately force state INIT, sio_c=1, sio_d_out=1, sio_d_oe=1, SCCB_done=0, busy=0, counters and frame cleared.
REQ-029 Reset mid-transaction SHALL abort the frame; after release, full INIT_WAIT elapses before the next SCCB_done.

Verification (QTR=4, INIT_WAIT=20)
REQ-030 Release reset -> SCCB_done single pulse exactly 20 cycles later; bus idle high throughout.
REQ-031 data_vld, then addr=8'h12 value=8'h14 -> decoded frame 42/12/14 with start+stop conditions; SCCB_done 1+464 cycles after capture.
REQ-032 data_vld pulses during BITS -> ignored; frame unchanged; only one SCCB_done.
REQ-033 Check sio_d_oe=0 exactly during bits 8, 17, 26 (16 cycles each); sio_d stable while sio_c=1 except start/stop.
REQ-034 rst_n asserted at bit 10 -> outputs idle in same cycle; restart yields new INIT pulse after 20 cycles.
REQ-035 Loop SCCB_done->data_vld via a 2-cycle delay model of the sequencer for 3 writes -> 3 correct back-to-back frames.
